// File: rtl/draw_pkg.sv
// -----------------------------------------------------------------------------
// draw_pkg
// Shared definitions for the drawing-port arbiter and its helpers:
//   - arbiter state encoding (IDLE / GRANT / RELEASE)
//   - engine index constants (0 = highest priority)
//   - VGA adapter dimensions and pixel field widths
//   - watchdog counter width helper
// -----------------------------------------------------------------------------
package draw_pkg;

  // VGA adapter geometry (160 x 120, 3-bit colour)
  localparam int VGA_W    = 160;
  localparam int VGA_H    = 120;
  localparam int X_W      = 8;
  localparam int Y_W      = 7;
  localparam int COLOUR_W = 3;

  // Drawing engines, listed in priority order (lowest index wins)
  localparam int ENG_CLEAR = 0;
  localparam int ENG_BG    = 1;
  localparam int ENG_CAR   = 2;
  localparam int ENG_WIN   = 3;
  localparam int ENG_MENU  = 4;
  localparam int NUM_ENG   = 5;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT   = 2'd1,
    ST_RELEASE = 2'd2
  } arb_state_t;

  // Watchdog width; never below one bit so tiny timeouts still elaborate.
  function automatic int wd_width(input int cycles);
    return (cycles > 2) ? $clog2(cycles) : 1;
  endfunction

endpackage

// File: rtl/draw_priority_enc.sv
// -----------------------------------------------------------------------------
// draw_priority_enc
// Combinational fixed-priority encoder: the lowest set bit of req wins.
// Ports:
//   req    in  N   request vector
//   onehot out N   one-hot of the winning index, zero when nothing is set
//   valid  out 1   any request set
// -----------------------------------------------------------------------------
module draw_priority_enc #(
  parameter int N = 5
) (
  input  logic [N-1:0] req,
  output logic [N-1:0] onehot,
  output logic         valid
);

  // Scan from the top down so the last hit, i.e. the lowest index, sticks.
  always_comb begin
    onehot = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        onehot    = '0;
        onehot[i] = 1'b1;
      end
    end
  end

  assign valid = |req;

endmodule

// File: rtl/draw_port_arbiter.sv
// -----------------------------------------------------------------------------
// draw_port_arbiter
// Shares the single VGA pixel-write port among the drawing engines. One engine
// is granted at a time under fixed priority (index 0 highest), the grant is held
// until that engine pulses done, drops its request, or the watchdog expires.
// Each grant is followed by one RELEASE cycle so engines never overlap.
// Ports:
//   clock, reset            clock, synchronous active-high reset
//   frame_tick              one-cycle frame pulse (gates new grants if FRAME_ALIGN)
//   req, done               per-engine request level / completion pulse
//   eng_x/y/colour/plot     flattened per-engine pixel streams
//   grant                   registered one-hot grant
//   vga_x/y/colour/plot     registered pixel port to the VGA adapter
//   busy                    state is not IDLE
//   timeout_err             sticky watchdog flag, cleared only by reset
// -----------------------------------------------------------------------------
module draw_port_arbiter #(
  parameter int NUM_REQ        = 5,
  parameter int X_W            = 8,
  parameter int Y_W            = 7,
  parameter int COLOUR_W       = 3,
  parameter int TIMEOUT_CYCLES = 32768,
  parameter int FRAME_ALIGN    = 0
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         frame_tick,
  input  logic [NUM_REQ-1:0]           req,
  input  logic [NUM_REQ-1:0]           done,
  input  logic [NUM_REQ*X_W-1:0]       eng_x,
  input  logic [NUM_REQ*Y_W-1:0]       eng_y,
  input  logic [NUM_REQ*COLOUR_W-1:0]  eng_colour,
  input  logic [NUM_REQ-1:0]           eng_plot,
  output logic [NUM_REQ-1:0]           grant,
  output logic [X_W-1:0]               vga_x,
  output logic [Y_W-1:0]               vga_y,
  output logic [COLOUR_W-1:0]          vga_colour,
  output logic                         vga_plot,
  output logic                         busy,
  output logic                         timeout_err
);

  import draw_pkg::*;

  localparam int             WD_W    = wd_width(TIMEOUT_CYCLES);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  arb_state_t         state, state_nxt;
  logic [NUM_REQ-1:0] grant_nxt;
  logic [NUM_REQ-1:0] pick;
  logic               pick_vld;
  logic               eligible;
  logic [WD_W-1:0]    wd, wd_nxt;
  logic               err_nxt;

  // Granted engine's signals, selected by the one-hot grant register
  logic [X_W-1:0]      sel_x;
  logic [Y_W-1:0]      sel_y;
  logic [COLOUR_W-1:0] sel_colour;
  logic                sel_plot;
  logic                sel_done;
  logic                sel_req;

  draw_priority_enc #(.N(NUM_REQ)) u_enc (
    .req    (req),
    .onehot (pick),
    .valid  (pick_vld)
  );

  // With FRAME_ALIGN a new grant can only start on the frame pulse.
  assign eligible = pick_vld && ((FRAME_ALIGN == 0) || frame_tick);

  // AND-OR mux; grant is one-hot or zero so at most one term contributes.
  always_comb begin
    sel_x      = '0;
    sel_y      = '0;
    sel_colour = '0;
    sel_plot   = 1'b0;
    sel_done   = 1'b0;
    sel_req    = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_x      = sel_x      | eng_x[i*X_W +: X_W];
        sel_y      = sel_y      | eng_y[i*Y_W +: Y_W];
        sel_colour = sel_colour | eng_colour[i*COLOUR_W +: COLOUR_W];
        sel_plot   = sel_plot   | eng_plot[i];
        sel_done   = sel_done   | done[i];
        sel_req    = sel_req    | req[i];
      end
    end
  end

  always_comb begin
    state_nxt = state;
    grant_nxt = grant;
    wd_nxt    = wd;
    err_nxt   = timeout_err;
    case (state)
      ST_IDLE: begin
        if (eligible) begin
          grant_nxt = pick;
          wd_nxt    = '0;
          state_nxt = ST_GRANT;
        end
      end
      ST_GRANT: begin
        // Saturating: the counter never wraps even if the exit is deferred.
        if (wd != WD_LAST) wd_nxt = wd + WD_W'(1);
        if (sel_done) begin
          grant_nxt = '0;
          state_nxt = ST_RELEASE;
        end else if (!sel_req) begin
          // Engine withdrew without finishing: release quietly.
          grant_nxt = '0;
          state_nxt = ST_RELEASE;
        end else if (wd == WD_LAST) begin
          err_nxt   = 1'b1;
          grant_nxt = '0;
          state_nxt = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        grant_nxt = '0;
        state_nxt = ST_IDLE;
      end
      default: begin
        grant_nxt = '0;
        state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= ST_IDLE;
      grant       <= '0;
      wd          <= '0;
      timeout_err <= 1'b0;
      vga_x       <= '0;
      vga_y       <= '0;
      vga_colour  <= '0;
      vga_plot    <= 1'b0;
    end else begin
      state       <= state_nxt;
      grant       <= grant_nxt;
      wd          <= wd_nxt;
      timeout_err <= err_nxt;
      case (state)
        // Forward every GRANT cycle, including the one carrying done, so the
        // engine's final pixel lands during the RELEASE cycle.
        ST_GRANT: begin
          vga_x      <= sel_x;
          vga_y      <= sel_y;
          vga_colour <= sel_colour;
          vga_plot   <= sel_plot;
        end
        ST_RELEASE: vga_plot <= 1'b0;
        default: ;  // coordinates hold their last value while idle
      endcase
    end
  end

  assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_draw_port_arbiter.sv
module tb_draw_port_arbiter;
  localparam int N = 5, XW = 8, YW = 7, CW = 3, T_A = 16;

  logic clock = 1'b0;
  logic reset, frame_tick;
  logic [N-1:0]    req, done, eng_plot;
  logic [N*XW-1:0] eng_x;
  logic [N*YW-1:0] eng_y;
  logic [N*CW-1:0] eng_colour;

  logic [N-1:0]  a_grant, b_grant;
  logic [XW-1:0] a_vga_x, b_vga_x;
  logic [YW-1:0] a_vga_y, b_vga_y;
  logic [CW-1:0] a_vga_colour, b_vga_colour;
  logic a_vga_plot, b_vga_plot, a_busy, b_busy, a_timeout_err, b_timeout_err;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state (engine-level view of the port)
  int            m_owner;
  int            m_held;
  bit            m_cool;
  bit            m_err;
  logic [XW-1:0] m_x;
  logic [YW-1:0] m_y;
  logic [CW-1:0] m_c;
  logic          m_p;
  bit [N-1:0]    drop;

  draw_port_arbiter #(.NUM_REQ(N), .X_W(XW), .Y_W(YW), .COLOUR_W(CW),
                      .TIMEOUT_CYCLES(T_A), .FRAME_ALIGN(0)) dut_a (
    .clock(clock), .reset(reset), .frame_tick(frame_tick), .req(req), .done(done),
    .eng_x(eng_x), .eng_y(eng_y), .eng_colour(eng_colour), .eng_plot(eng_plot),
    .grant(a_grant), .vga_x(a_vga_x), .vga_y(a_vga_y), .vga_colour(a_vga_colour),
    .vga_plot(a_vga_plot), .busy(a_busy), .timeout_err(a_timeout_err));

  draw_port_arbiter #(.NUM_REQ(N), .X_W(XW), .Y_W(YW), .COLOUR_W(CW),
                      .TIMEOUT_CYCLES(64), .FRAME_ALIGN(1)) dut_b (
    .clock(clock), .reset(reset), .frame_tick(frame_tick), .req(req), .done(done),
    .eng_x(eng_x), .eng_y(eng_y), .eng_colour(eng_colour), .eng_plot(eng_plot),
    .grant(b_grant), .vga_x(b_vga_x), .vga_y(b_vga_y), .vga_colour(b_vga_colour),
    .vga_plot(b_vga_plot), .busy(b_busy), .timeout_err(b_timeout_err));

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_inputs();
    req = '0; done = '0; eng_plot = '0; frame_tick = 1'b0;
    eng_x = '0; eng_y = '0; eng_colour = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic set_pix(input int i, input logic [XW-1:0] x, input logic [YW-1:0] y,
                         input logic [CW-1:0] c, input logic p);
    eng_x[i*XW +: XW]      = x;
    eng_y[i*YW +: YW]      = y;
    eng_colour[i*CW +: CW] = c;
    eng_plot[i]            = p;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1'b1;
    tick(); tick();
    n_tests++;
    if ({a_grant, a_vga_plot, a_busy, a_timeout_err} !== 8'b0 ||
        {a_vga_x, a_vga_y, a_vga_colour} !== 18'b0) begin
      n_fail++;
      $display("FAIL reset_state: grant=%b plot=%b busy=%b err=%b x=%0d y=%0d c=%0d, want all zero",
               a_grant, a_vga_plot, a_busy, a_timeout_err, a_vga_x, a_vga_y, a_vga_colour);
    end
    reset = 1'b0;
  endtask

  task automatic test_basic();
    clear_inputs(); do_reset();
    req = 5'b00010;
    set_pix(1, 8'd10, 7'd20, 3'b101, 1'b1);
    set_pix(3, 8'd99, 7'd99, 3'b111, 1'b1);  // not granted, must be ignored
    tick();
    n_tests++;
    if (a_grant !== 5'b00010 || a_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_grant: grant=%b busy=%b, want 00010 busy=1", a_grant, a_busy);
    end
    tick();
    n_tests++;
    if (a_vga_x !== 8'd10 || a_vga_y !== 7'd20 || a_vga_colour !== 3'b101 || a_vga_plot !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_pixel: x=%0d y=%0d c=%b plot=%b, want 10 20 101 1",
               a_vga_x, a_vga_y, a_vga_colour, a_vga_plot);
    end
    done[1] = 1'b1;
    eng_plot[1] = 1'b0;
    tick();
    n_tests++;
    if (a_grant !== 5'b0 || a_busy !== 1'b1 || a_vga_plot !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_release: grant=%b busy=%b plot=%b, want 0 1 0", a_grant, a_busy, a_vga_plot);
    end
    done = '0; req = '0;
    tick();
    n_tests++;
    if (a_grant !== 5'b0 || a_busy !== 1'b0 || a_vga_x !== 8'd10) begin
      n_fail++;
      $display("FAIL basic_idle: grant=%b busy=%b x=%0d, want 0 0 10(held)", a_grant, a_busy, a_vga_x);
    end
  endtask

  task automatic test_priority();
    int order [3] = '{0, 2, 4};
    clear_inputs(); do_reset();
    req = 5'b10101;
    for (int k = 0; k < 3; k++) begin
      int e = order[k];
      logic [N-1:0] want;
      want = '0;
      want[e] = 1'b1;
      tick();
      n_tests++;
      if (a_grant !== want) begin
        n_fail++;
        $display("FAIL priority_grant%0d: grant=%b want %b", k, a_grant, want);
      end
      done[e] = 1'b1;
      tick();
      n_tests++;
      if (a_grant !== 5'b0 || a_vga_plot !== 1'b0) begin
        n_fail++;
        $display("FAIL priority_release%0d: grant=%b plot=%b want 0 0", k, a_grant, a_vga_plot);
      end
      done = '0;
      req[e] = 1'b0;
      tick();
      n_tests++;
      if (a_grant !== 5'b0) begin
        n_fail++;
        $display("FAIL priority_gap%0d: grant=%b want 0", k, a_grant);
      end
    end
    n_tests++;
    if (a_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL priority_end_busy: busy=%b want 0", a_busy);
    end
  endtask

  task automatic test_no_preempt();
    clear_inputs(); do_reset();
    req = 5'b10000;
    tick();
    req[0] = 1'b1;
    repeat (4) begin
      n_tests++;
      if (a_grant !== 5'b10000) begin
        n_fail++;
        $display("FAIL no_preempt_hold: grant=%b want 10000", a_grant);
      end
      tick();
    end
    done[4] = 1'b1;
    tick();
    done = '0;
    req[4] = 1'b0;
    tick();
    n_tests++;
    if (a_grant !== 5'b0) begin
      n_fail++;
      $display("FAIL no_preempt_gap: grant=%b want 0", a_grant);
    end
    tick();
    n_tests++;
    if (a_grant !== 5'b00001) begin
      n_fail++;
      $display("FAIL no_preempt_winner: grant=%b want 00001", a_grant);
    end
    done[0] = 1'b1;
    tick();
    done = '0; req = '0;
    tick();
  endtask

  task automatic test_timeout();
    clear_inputs(); do_reset();
    req = 5'b00100;
    for (int k = 1; k <= T_A; k++) begin
      tick();
      n_tests++;
      if (a_grant !== 5'b00100 || a_timeout_err !== 1'b0) begin
        n_fail++;
        $display("FAIL timeout_hold%0d: grant=%b err=%b want 00100 0", k, a_grant, a_timeout_err);
      end
    end
    tick();
    n_tests++;
    if (a_grant !== 5'b0 || a_timeout_err !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout_fire: grant=%b err=%b want 0 1", a_grant, a_timeout_err);
    end
    req = '0;
    tick();
    req = 5'b00010;
    tick();
    n_tests++;
    if (a_grant !== 5'b00010 || a_timeout_err !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout_sticky: grant=%b err=%b want 00010 1", a_grant, a_timeout_err);
    end
    done[1] = 1'b1;
    tick();
    done = '0; req = '0;
    tick();
    do_reset();
    n_tests++;
    if (a_timeout_err !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_clear: err=%b want 0", a_timeout_err);
    end
  endtask

  task automatic test_frame_align();
    int bad;
    clear_inputs(); do_reset();
    repeat (4) tick();
    req[1] = 1'b1;
    set_pix(3, 8'd7, 7'd7, 3'b011, 1'b1);
    bad = 0;
    repeat (35) begin
      tick();
      if (b_grant !== 5'b0 || b_vga_plot !== 1'b0) bad++;
    end
    n_tests++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL frame_wait: %0d cycles with grant/plot set before frame_tick, want 0", bad);
    end
    frame_tick = 1'b1;
    tick();
    frame_tick = 1'b0;
    n_tests++;
    if (b_grant !== 5'b00010) begin
      n_fail++;
      $display("FAIL frame_grant: grant=%b want 00010", b_grant);
    end
    bad = 0;
    repeat (3) begin
      tick();
      if (b_vga_plot !== 1'b0) bad++;
    end
    n_tests++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL frame_foreign_plot: %0d cycles with vga_plot=1 from non-granted engine, want 0", bad);
    end
    done[1] = 1'b1;
    tick();
    done = '0; req = '0; eng_plot = '0;
    tick();
  endtask

  task automatic test_reset_mid();
    clear_inputs(); do_reset();
    req = 5'b00001;
    set_pix(0, 8'd5, 7'd6, 3'b001, 1'b1);
    tick(); tick();
    n_tests++;
    if (a_grant !== 5'b00001 || a_vga_plot !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid_pre: grant=%b plot=%b want 00001 1", a_grant, a_vga_plot);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_tests++;
    if (a_grant !== 5'b0 || a_vga_plot !== 1'b0 || a_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid: grant=%b plot=%b busy=%b want 0 0 0", a_grant, a_vga_plot, a_busy);
    end
    clear_inputs();
  endtask

  task automatic test_random();
    logic [N-1:0] m_grant;
    bit           m_busy;
    clear_inputs(); do_reset();
    m_owner = -1; m_held = 0; m_cool = 0; m_err = 0;
    m_x = '0; m_y = '0; m_c = '0; m_p = 1'b0; drop = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      // Engines: owner finishes or aborts at random, others request at random.
      done = '0;
      frame_tick = 1'($urandom_range(0, 1));
      for (int i = 0; i < N; i++) begin
        eng_x[i*XW +: XW]      = XW'($urandom);
        eng_y[i*YW +: YW]      = YW'($urandom);
        eng_colour[i*CW +: CW] = CW'($urandom);
        eng_plot[i]            = 1'($urandom_range(0, 1));
        if (drop[i]) begin
          req[i] = 1'b0;
          drop[i] = 1'b0;
        end else if (i == m_owner) begin
          int r = $urandom_range(0, 49);
          if (r < 8) begin
            done[i] = 1'b1;
            drop[i] = 1'b1;
          end else if (r == 8) begin
            req[i] = 1'b0;
          end
        end else begin
          if (!req[i] && $urandom_range(0, 7) == 0) req[i] = 1'b1;
          if ($urandom_range(0, 9) == 0) done[i] = 1'b1;
        end
      end
      @(negedge clock);
      // Model: one engine owns the port until done/abort/16 held cycles,
      // then the port sits unowned for two cycles before the next pick.
      if (m_owner >= 0) begin
        m_x = eng_x[m_owner*XW +: XW];
        m_y = eng_y[m_owner*YW +: YW];
        m_c = eng_colour[m_owner*CW +: CW];
        m_p = eng_plot[m_owner];
        m_held++;
        if (done[m_owner] || !req[m_owner] || m_held == T_A) begin
          if (!done[m_owner] && req[m_owner]) m_err = 1'b1;
          m_owner = -1;
          m_cool  = 1'b1;
        end
      end else if (m_cool) begin
        m_cool = 1'b0;
        m_p    = 1'b0;
      end else if (req != '0) begin
        for (int i = N - 1; i >= 0; i--) if (req[i]) m_owner = i;
        m_held = 0;
      end
      m_grant = '0;
      if (m_owner >= 0) m_grant[m_owner] = 1'b1;
      m_busy = (m_owner >= 0) || m_cool;
      tick();
      n_tests++;
      if (a_grant !== m_grant || a_vga_plot !== m_p || a_vga_x !== m_x || a_vga_y !== m_y ||
          a_vga_colour !== m_c || a_busy !== m_busy || a_timeout_err !== m_err) begin
        n_fail++;
        $display("FAIL random_c%0d: got g=%b p=%b x=%0d y=%0d c=%0d busy=%b err=%b want g=%b p=%b x=%0d y=%0d c=%0d busy=%b err=%b",
                 cyc, a_grant, a_vga_plot, a_vga_x, a_vga_y, a_vga_colour, a_busy, a_timeout_err,
                 m_grant, m_p, m_x, m_y, m_c, m_busy, m_err);
      end
    end
    clear_inputs();
  endtask

  initial begin
    reset = 1'b1;
    clear_inputs();
    test_reset();
    test_basic();
    test_priority();
    test_no_preempt();
    test_timeout();
    test_frame_align();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish, %0d tests run", n_tests);
    $fatal(1);
  end

endmodule

// File: doc/draw_port_arbiter.md
Name: draw_port_arbiter

Overview:
- Shares the single VGA adapter pixel-write port (x, y, colour, plot) among the drawing engines started by the game control FSM: clear, background, car, win banner and menu.
- Engines raise a request. The arbiter grants exactly one at a time under fixed priority and holds the grant until that engine signals done.
- It registers the granted engine's pixel stream onto the VGA port and guards against hung engines with a watchdog.

Parameters:
- NUM_REQ, 5, number of drawing engines; index 0 is highest priority (0 clear, 1 bg, 2 car, 3 win, 4 menu).
- X_W, 8, pixel x width (160-column adapter).
- Y_W, 7, pixel y width (120-row adapter).
- COLOUR_W, 3, colour width.
- TIMEOUT_CYCLES, 32768, maximum cycles a grant may be held; must be at least 160*120 + margin.
- FRAME_ALIGN, 0, if 1 a new grant may only start in a cycle where frame_tick=1.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- frame_tick  in  1  one-cycle pulse per frame (oneframe); used only when FRAME_ALIGN=1
- req  in  NUM_REQ  per-engine request, level, held until done
- done  in  NUM_REQ  per-engine completion, one-cycle pulse
- eng_x  in  NUM_REQ*X_W  flattened engine x; engine i occupies bits [i*X_W +: X_W]
- eng_y  in  NUM_REQ*Y_W  flattened engine y
- eng_colour  in  NUM_REQ*COLOUR_W  flattened engine colour
- eng_plot  in  NUM_REQ  per-engine write strobe
- grant  out  NUM_REQ  one-hot grant, registered
- vga_x  out  X_W  registered x to the VGA adapter
- vga_y  out  Y_W  registered y
- vga_colour  out  COLOUR_W  registered colour
- vga_plot  out  1  registered write enable
- busy  out  1  high whenever state is not IDLE
- timeout_err  out  1  sticky; cleared only by reset

Behaviour:
- Reset is synchronous and active-high. On reset: state=IDLE, grant=0, vga_x/vga_y/vga_colour=0, vga_plot=0, busy=0, timeout_err=0, watchdog counter=0. Reset asserted mid-grant drops grant and vga_plot on the next edge.
- State machine:
  - IDLE:
    - If any req bit is set (and frame_tick=1 when FRAME_ALIGN=1), select the lowest set index, load grant with its one-hot value, clear the watchdog and go to GRANT.
    - Grant is visible one cycle after req is sampled.
    - If no request is eligible, stay in IDLE.
  - GRANT (granted index g):
    - Each cycle: vga_x/y/colour <= eng_*[g] and vga_plot <= eng_plot[g]. Pixel latency is 1 cycle from engine to port.
    - Pixels from non-granted engines are ignored entirely.
    - done[g]=1 -> RELEASE. The pixel presented in the same cycle as done is still forwarded.
    - req[g]=0 without done is an abort -> RELEASE, timeout_err is unchanged.
    - Watchdog increments each GRANT cycle. On reaching TIMEOUT_CYCLES-1 without done: set timeout_err, go to RELEASE.
    - done bits of non-granted engines are ignored.
  - RELEASE:
    - One dead cycle: grant=0, vga_plot=0. Then go to IDLE.
    - Guarantees no overlap between consecutive engines. Minimum re-grant gap is 2 cycles after done.
- Priority is fixed with no preemption. A higher-priority request arriving during GRANT waits for RELEASE, then wins in IDLE over lower requests.
- If multiple done bits are set simultaneously, only done[g] is considered.
- grant is always one-hot or zero; it is never multi-hot.
- vga_x/y/colour hold their last value when vga_plot=0.
- Watchdog is a $clog2(TIMEOUT_CYCLES)-bit counter with no wrap; it saturates at the terminal count.

Decomposition:
- Shared package draw_pkg holds:
  - state encodings ST_IDLE, ST_GRANT, ST_RELEASE;
  - engine index constants ENG_CLEAR=0, ENG_BG=1, ENG_CAR=2, ENG_WIN=3, ENG_MENU=4;
  - VGA dimension constants (160, 120) and the widths X_W, Y_W, COLOUR_W.
- One sub-module, draw_priority_enc: combinational NUM_REQ-bit lowest-index-first encoder producing a one-hot output plus a valid flag. The arbiter instantiates it once.

Test Plan:
- Reset, then req=5'b00010 -> grant=5'b00010 one cycle later, busy=1. Engine 1 drives x=10, y=20, colour=3'b101, plot=1 -> vga_* matches one cycle later. done[1] -> grant=0 for one cycle, then busy=0.
- req=5'b10101 simultaneous -> grants in order 5'b00001, 5'b00100, 5'b10000, each separated by one RELEASE cycle with vga_plot=0.
- During a grant to engine 4, raise req[0] -> engine 4 keeps its grant until done[4]; engine 0 is granted 2 cycles after done[4].
- TIMEOUT_CYCLES=16, engine 2 never asserts done -> after 16 GRANT cycles timeout_err=1 and grant=0; timeout_err stays 1 through subsequent grants until reset.
- FRAME_ALIGN=1, req[1] raised at cycle 5, frame_tick pulses at cycle 40 -> grant=0 through cycle 40, grant=5'b00010 at cycle 41. A non-granted engine plotting meanwhile never produces vga_plot=1.
- Assert reset mid-GRANT while eng_plot=1 -> next cycle grant=0, vga_plot=0, busy=0.
